rect_meter: RTL and testbench
=============================

RECT_METER -- requirements
Module: rect_meter

Interface
REQ-001 Parameter CNT_W, default 16: width of td, th and tl measurement counters.
REQ-002 Parameter SYNC_STAGES, default 2: depth of the sig_in synchronizer, minimum 2.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request one measurement; sampled only in IDLE, or in DONE together with ack.
REQ-006 sig_in  in  1  asynchronous rectangular waveform under test.
REQ-007 ack  in  1  consumer acknowledge of a completed result.
REQ-008 td  out  CNT_W  delay from start to first detected rising edge, in cycles.
REQ-009 th  out  CNT_W  high time, in cycles.
REQ-010 tl  out  CNT_W  low time, in cycles.
REQ-011 period  out  CNT_W+1  th+tl, unsigned, no truncation.
REQ-012 valid  out  1  result fields stable and ready.
REQ-013 ovf  out  1  measurement aborted on counter saturation.
REQ-014 busy  out  1  high in WAIT_RISE, HIGH and LOW.

Function
REQ-015 sig_in SHALL pass through SYNC_STAGES flops; edges SHALL be detected by comparing the synchronized value with its one-cycle-delayed copy; pulses shorter than one clock MAY be missed.
REQ-016 FSM states SHALL be IDLE, WAIT_RISE, HIGH, LOW, DONE.
REQ-017 IDLE: start=1 -> WAIT_RISE; ovf cleared; count loaded 0.
REQ-018 WAIT_RISE: count increments each cycle; rising edge -> td = count+1, count = 0, HIGH; a falling edge is ignored (sig_in high at start waits for the next rise).
REQ-019 HIGH: falling edge -> th = count+1, count = 0, LOW.
REQ-020 LOW: rising edge -> tl = count+1, period = th+tl, DONE.
REQ-021 Captured values SHALL equal the number of cycles spent in the state, including the edge cycle; td therefore includes SYNC_STAGES of synchronizer latency, while th and tl do not.
REQ-022 Count SHALL saturate at 2^CNT_W-1. On reaching saturation in any busy state: ovf = 1, the current field and all not-yet-measured fields = 2^CNT_W-1, period = th+tl, then DONE.
REQ-023 DONE: valid = 1 and all result fields hold until ack=1; ack -> IDLE, valid = 0 on the next cycle.
REQ-024 ack with start in the same cycle in DONE -> WAIT_RISE directly; valid drops on the next cycle.
REQ-025 start SHALL be ignored while busy; ack SHALL be ignored outside DONE.
REQ-026 Result fields SHALL change only at capture and SHALL hold through IDLE until the next capture.
REQ-027 ovf SHALL be sticky until the next accepted start.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, with all outputs, the count and the synchronizer flops set to 0, regardless of current state.
REQ-029 After rst_n deasserts, the first start SHALL be accepted no earlier than the first rising clk edge.

Verification (CNT_W=8, SYNC_STAGES=2)
REQ-030 start; sig_in rises 20 cycles later, high 10 cycles, low 7 cycles, rises -> td=22, th=10, tl=7, period=17, valid=1, ovf=0.
REQ-031 start with sig_in held low -> 255 cycles later valid=1, ovf=1, td=th=tl=255, period=510.
REQ-032 sig_in high at start, falls after 5 cycles, rises after a further 8 -> td counts all 13 cycles plus 2 synchronizer cycles = 15, and no spurious th capture.
REQ-033 In DONE, ack and start in the same cycle -> valid=0 next cycle, busy=1, new result captured; a start pulse while busy -> no effect on the result.
REQ-034 rst_n pulsed low mid-HIGH -> all outputs 0 asynchronously, state IDLE, then a clean measurement succeeds afterwards.

Source files
------------

// File: rtl/rect_meter_if.sv
// Handshake and result bundle between a rect_meter and its controller.
// The controller (master) drives start/ack and the waveform; the meter (slave) returns results.
interface rect_meter_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             sig_in;
    logic             ack;
    logic [CNT_W-1:0] td;
    logic [CNT_W-1:0] th;
    logic [CNT_W-1:0] tl;
    logic [CNT_W:0]   period;
    logic             valid;
    logic             ovf;
    logic             busy;

    modport master (
        output start, sig_in, ack,
        input  td, th, tl, period, valid, ovf, busy
    );

    modport slave (
        input  start, sig_in, ack,
        output td, th, tl, period, valid, ovf, busy
    );
endinterface

// File: rtl/rect_meter.sv
// Measures start-to-rise delay, high time and low time of an asynchronous rectangular
// waveform in clock cycles, with saturation abort and a valid/ack result handshake.
module rect_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    rect_meter_if.slave mif
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RISE,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W:0]   PERIOD_SAT = {1'b0, CNT_MAX} + {1'b0, CNT_MAX};

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] td_reg, td_next;
    logic [CNT_W-1:0] th_reg, th_next;
    logic [CNT_W-1:0] tl_reg, tl_next;
    logic [CNT_W:0]   period_reg, period_next;
    logic             ovf_reg, ovf_next;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sig_d_reg;
    logic                   sig_s;
    logic                   rise;
    logic                   fall;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   at_sat;

    // Synchronizer plus one delayed copy of its output for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= '0;
            sig_d_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], mif.sig_in};
            sig_d_reg <= sig_s;
        end
    end

    assign sig_s   = sync_reg[SYNC_STAGES-1];
    assign rise    = sig_s & ~sig_d_reg;
    assign fall    = ~sig_s & sig_d_reg;
    assign cnt_inc = count_reg + CNT_ONE;
    // The count about to reach its ceiling aborts the measurement, even on an edge cycle.
    assign at_sat  = (cnt_inc == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            count_reg  <= '0;
            td_reg     <= '0;
            th_reg     <= '0;
            tl_reg     <= '0;
            period_reg <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            td_reg     <= td_next;
            th_reg     <= th_next;
            tl_reg     <= tl_next;
            period_reg <= period_next;
            ovf_reg    <= ovf_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        td_next     = td_reg;
        th_next     = th_reg;
        tl_next     = tl_reg;
        period_next = period_reg;
        ovf_next    = ovf_reg;
        case (state_reg)
            S_IDLE: begin
                if (mif.start) begin
                    state_next = S_WAIT_RISE;
                    ovf_next   = 1'b0;
                    count_next = '0;
                end
            end
            S_WAIT_RISE: begin
                if (at_sat) begin
                    state_next  = S_DONE;
                    ovf_next    = 1'b1;
                    td_next     = CNT_MAX;
                    th_next     = CNT_MAX;
                    tl_next     = CNT_MAX;
                    period_next = PERIOD_SAT;
                end else if (rise) begin
                    state_next = S_HIGH;
                    td_next    = cnt_inc;
                    count_next = '0;
                end else begin
                    count_next = cnt_inc;
                end
            end
            S_HIGH: begin
                if (at_sat) begin
                    state_next  = S_DONE;
                    ovf_next    = 1'b1;
                    th_next     = CNT_MAX;
                    tl_next     = CNT_MAX;
                    period_next = PERIOD_SAT;
                end else if (fall) begin
                    state_next = S_LOW;
                    th_next    = cnt_inc;
                    count_next = '0;
                end else begin
                    count_next = cnt_inc;
                end
            end
            S_LOW: begin
                if (at_sat) begin
                    state_next  = S_DONE;
                    ovf_next    = 1'b1;
                    tl_next     = CNT_MAX;
                    period_next = {1'b0, th_reg} + {1'b0, CNT_MAX};
                end else if (rise) begin
                    state_next  = S_DONE;
                    tl_next     = cnt_inc;
                    period_next = {1'b0, th_reg} + {1'b0, cnt_inc};
                end else begin
                    count_next = cnt_inc;
                end
            end
            S_DONE: begin
                // Acknowledge with a fresh start chains straight into the next measurement.
                if (mif.ack) begin
                    if (mif.start) begin
                        state_next = S_WAIT_RISE;
                        ovf_next   = 1'b0;
                        count_next = '0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign mif.td     = td_reg;
    assign mif.th     = th_reg;
    assign mif.tl     = tl_reg;
    assign mif.period = period_reg;
    assign mif.ovf    = ovf_reg;
    assign mif.valid  = (state_reg == S_DONE);
    assign mif.busy   = (state_reg == S_WAIT_RISE) || (state_reg == S_HIGH) || (state_reg == S_LOW);
endmodule

// File: tb/tb_rect_meter.sv
// Directed and randomized measurements of rect_meter (CNT_W=8, SYNC_STAGES=2) checked
// against a cycle-level behavioural model of the waveform timings.
module tb_rect_meter;
    localparam int CNT_W  = 8;
    localparam int SAT    = 255;
    localparam int BUDGET = 700;
    localparam int NEVER  = 100000;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    rect_meter_if #(.CNT_W(CNT_W)) mif ();

    rect_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .mif  (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Value of sig_in as sampled at clock edge k after the start edge.
    function automatic bit sample(input bit pre_high, input int fall_at, input int d,
                                  input int h, input int l, input int k);
        if (pre_high && k < fall_at) return 1'b1;
        if (k < d) return 1'b0;
        if (k < d + h) return 1'b1;
        if (k < d + h + l) return 1'b0;
        return 1'b1;
    endfunction

    // Expected results: each field is the sampled duration (td adds two synchronizer
    // cycles); the first field reaching 255 cycles aborts and saturates the rest.
    task automatic model(input int d, input int h, input int l,
                         output int etd, output int eth, output int etl,
                         output int eper, output int eovf, output int elat);
        if (d + 2 >= SAT) begin
            etd = SAT; eth = SAT; etl = SAT; eovf = 1; elat = SAT;
        end else if (h >= SAT) begin
            etd = d + 2; eth = SAT; etl = SAT; eovf = 1; elat = d + 2 + SAT;
        end else if (l >= SAT) begin
            etd = d + 2; eth = h; etl = SAT; eovf = 1; elat = d + 2 + h + SAT;
        end else begin
            etd = d + 2; eth = h; etl = l; eovf = 0; elat = d + 2 + h + l;
        end
        eper = eth + etl;
    endtask

    task automatic start_meas(input bit pre_high);
        mif.sig_in = pre_high;
        repeat (4) @(negedge clk);
        mif.start = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
    endtask

    // Drives the waveform edge by edge after the start edge and checks the captured result.
    task automatic measure(input string name, input bit pre_high, input int fall_at,
                           input int d, input int h, input int l, input int busy_start_k);
        int etd, eth, etl, eper, eovf, elat;
        int lat;
        model(d, h, l, etd, eth, etl, eper, eovf, elat);
        lat = -1;
        for (int k = 1; k <= BUDGET; k++) begin
            mif.sig_in = sample(pre_high, fall_at, d, h, l, k);
            mif.start  = (k == busy_start_k);
            @(negedge clk);
            if (k == 1) check({name, ".busy"}, mif.busy, 1);
            if (mif.valid) begin
                lat = k;
                break;
            end
        end
        mif.start = 1'b0;
        check({name, ".latency"}, lat, elat);
        check({name, ".td"}, mif.td, etd);
        check({name, ".th"}, mif.th, eth);
        check({name, ".tl"}, mif.tl, etl);
        check({name, ".period"}, mif.period, eper);
        check({name, ".ovf"}, mif.ovf, eovf);
        repeat (3) @(negedge clk);
        check({name, ".valid_hold"}, mif.valid, 1);
        check({name, ".td_hold"}, mif.td, etd);
        $display("[TB] %s d=%0d h=%0d l=%0d -> td=%0d th=%0d tl=%0d period=%0d ovf=%0d lat=%0d",
                 name, d, h, l, mif.td, mif.th, mif.tl, mif.period, mif.ovf, lat);
    endtask

    task automatic ack_only(input string name);
        logic [31:0] td_before;
        logic [31:0] per_before;
        td_before  = 32'(mif.td);
        per_before = 32'(mif.period);
        mif.ack = 1'b1;
        @(negedge clk);
        mif.ack = 1'b0;
        check({name, ".valid_after_ack"}, mif.valid, 0);
        check({name, ".busy_after_ack"}, mif.busy, 0);
        repeat (2) @(negedge clk);
        check({name, ".td_idle_hold"}, mif.td, td_before);
        check({name, ".period_idle_hold"}, mif.period, per_before);
    endtask

    initial begin
        int d, h, l, bk;
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        mif.start  = 1'b0;
        mif.ack    = 1'b0;
        mif.sig_in = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.td", mif.td, 0);
        check("reset.period", mif.period, 0);
        check("reset.valid", mif.valid, 0);
        check("reset.busy", mif.busy, 0);
        check("reset.ovf", mif.ovf, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ack outside DONE has no effect
        mif.ack = 1'b1;
        @(negedge clk);
        mif.ack = 1'b0;
        check("idle_ack.busy", mif.busy, 0);

        start_meas(1'b0);
        measure("basic", 1'b0, 0, 20, 10, 7, 0);
        ack_only("basic");

        start_meas(1'b0);
        measure("no_edge", 1'b0, 0, NEVER, 0, 0, 0);
        ack_only("no_edge");

        start_meas(1'b1);
        measure("high_at_start", 1'b1, 5, 13, 10, 6, 0);
        ack_only("high_at_start");

        start_meas(1'b0);
        measure("sat_high", 1'b0, 0, 9, 300, 5, 0);
        ack_only("sat_high");

        start_meas(1'b0);
        measure("sat_low", 1'b0, 0, 6, 12, 300, 0);
        ack_only("sat_low");

        // ovf from sat_low must clear on the next accepted start
        start_meas(1'b0);
        check("ovf_cleared_on_start", mif.ovf, 0);
        measure("after_ovf", 1'b0, 0, 8, 4, 3, 5);

        // ack together with start while DONE chains into a new measurement
        mif.ack   = 1'b1;
        mif.start = 1'b1;
        @(negedge clk);
        mif.ack   = 1'b0;
        mif.start = 1'b0;
        check("chain.valid", mif.valid, 0);
        check("chain.busy", mif.busy, 1);
        measure("chain", 1'b1, 1, 10, 15, 9, 4);
        ack_only("chain");

        for (int i = 0; i < 6; i++) begin
            d  = int'($urandom_range(60, 2));
            h  = int'($urandom_range(40, 1));
            l  = int'($urandom_range(40, 1));
            bk = int'($urandom_range(d + h, 2));
            start_meas(1'b0);
            measure($sformatf("rand%0d", i), 1'b0, 0, d, h, l, bk);
            ack_only($sformatf("rand%0d", i));
        end

        // asynchronous reset in the middle of the high phase
        start_meas(1'b0);
        for (int k = 1; k <= 20; k++) begin
            mif.sig_in = sample(1'b0, 0, 5, 50, 20, k);
            @(negedge clk);
        end
        check("mid_high.busy", mif.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.td", mif.td, 0);
        check("async_rst.th", mif.th, 0);
        check("async_rst.tl", mif.tl, 0);
        check("async_rst.period", mif.period, 0);
        check("async_rst.valid", mif.valid, 0);
        check("async_rst.ovf", mif.ovf, 0);
        check("async_rst.busy", mif.busy, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        mif.sig_in = 1'b0;
        $display("[TB] async reset applied mid-HIGH");
        start_meas(1'b0);
        measure("post_reset", 1'b0, 0, 11, 6, 14, 0);
        ack_only("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
